// File: rtl/bcd_addsub_seq_if.sv
// Operand/result bundle for the digit-serial BCD adder/subtractor.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface bcd_addsub_seq_if #(
    parameter int DIGITS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   result;
    logic                  cout;
    logic                  neg;
    logic                  err;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, neg, err
    );

    // The arithmetic block itself.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, neg, err
    );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD add/sub, one digit per clock LSD first; sub returns sign+magnitude.
// Latency: DIGITS cycles from acceptance to out_valid (2*DIGITS for a negative difference).
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready low while busy.
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bcd_addsub_seq_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    res_q, res_d;
    logic            sub_q, sub_d, bad_q, bad_d, carry_q, carry_d;
    logic            cout_q, cout_d, neg_q, neg_d, err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [3:0]      dig_x, dig_y, dig_sum;
    logic [4:0]      dig_raw;
    logic            dig_c;
    logic            in_bad;

    // Flag any non-decimal digit on the operands being offered.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a[i*4 +: 4] > 4'd9 || bus.b[i*4 +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // Shared one-digit BCD adder: ADD uses a + b (or 9's complement of b), FIX uses 9's complement of the partial result.
    always_comb begin
        dig_x = a_q[cnt_q*4 +: 4];
        dig_y = sub_q ? (4'd9 - b_q[cnt_q*4 +: 4]) : b_q[cnt_q*4 +: 4];
        if (state_q == FIX) begin
            dig_x = 4'd9 - work_q[cnt_q*4 +: 4];
            dig_y = 4'd0;
        end
        dig_raw = {1'b0, dig_x} + {1'b0, dig_y} + {4'd0, carry_q};
        dig_c   = (dig_raw > 5'd9);
        dig_sum = dig_c ? (dig_raw[3:0] + 4'd6) : dig_raw[3:0];
    end

    // Next-state and datapath update; published result/flags change only on acceptance and on entry to DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        bad_d   = bad_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        res_d   = res_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    bad_d   = in_bad;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    work_d  = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Invalid operands still walk the counter so latency is data-independent.
                if (!bad_q) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            work_d[i*4 +: 4] = dig_sum;
                        end
                    end
                    carry_d = dig_c;
                end
                if (cnt_q == LAST) begin
                    if (bad_q) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (!sub_q) begin
                        res_d   = work_d;
                        cout_d  = dig_c;
                        state_d = DONE;
                    end else if (dig_c) begin
                        // End carry out of ten's complement means a >= b.
                        res_d   = work_d;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        carry_d = 1'b1;
                        state_d = FIX;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                // Re-complement the intermediate: 10^DIGITS - r gives the magnitude.
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        work_d[i*4 +: 4] = dig_sum;
                    end
                end
                carry_d = dig_c;
                if (cnt_q == LAST) begin
                    res_d   = work_d;
                    neg_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            bad_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            bad_q   <= bad_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Bench for bcd_addsub_seq: directed vectors, randomized ops vs an integer-arithmetic model,
// backpressure, input isolation while busy, and reset in the middle of ADD and FIX.
module tb_bcd_addsub_seq;
    localparam int D = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bcd_addsub_seq_if #(.DIGITS(D)) bus ();

    bcd_addsub_seq #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [15:0] x);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: plain decimal arithmetic on the operand values.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic n,
                         output logic e, output int lat);
        int av, bv, v;
        e = 1'b0;
        for (int i = 0; i < D; i++)
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e = 1'b1;
        r = '0; c = 1'b0; n = 1'b0; lat = D;
        if (!e) begin
            av = bcd2int(a);
            bv = bcd2int(b);
            if (!s) begin
                v = av + bv;
                c = (v >= 10000);
                r = int2bcd(v % 10000);
            end else if (av >= bv) begin
                r = int2bcd(av - bv);
            end else begin
                n = 1'b1;
                r = int2bcd(bv - av);
                lat = 2 * D;
            end
        end
    endtask

    // Offer one op (called #1 after an edge with the DUT idle), wait for the result, then complete the handshake if out_ready is high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [18:0] got, output int lat, output bit to,
                          output logic [18:0] post_acc, output logic rdy_acc);
        bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        post_acc = {bus.result, bus.cout, bus.neg, bus.err};
        rdy_acc  = bus.in_ready;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = ~s;
        lat = 0; to = 1'b0;
        while (!bus.out_valid && !to) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 40) to = 1'b1;
        end
        got = {bus.result, bus.cout, bus.neg, bus.err};
        if (bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++;
        if ({bus.result, bus.cout, bus.neg, bus.err} !== 19'd0)
            begin errors++; $display("FAIL reset_outputs got %h exp 0", {bus.result, bus.cout, bus.neg, bus.err}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [15:0] va [8] = '{16'h0456, 16'h9999, 16'h5000, 16'h0100, 16'h0250, 16'h0042, 16'h00A1, 16'h0001};
        logic [15:0] vb [8] = '{16'h0789, 16'h0001, 16'h5000, 16'h0250, 16'h0100, 16'h0042, 16'h0001, 16'h0001};
        logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [18:0] ve [8] = '{{16'h1245, 3'b000}, {16'h0000, 3'b100}, {16'h0000, 3'b100},
                                {16'h0150, 3'b010}, {16'h0150, 3'b000}, {16'h0000, 3'b000},
                                {16'h0000, 3'b001}, {16'h0002, 3'b000}};
        int          vl [8] = '{4, 4, 4, 8, 4, 4, 4, 4};
        logic [18:0] got, pa;
        logic        ra;
        int          lat;
        bit          to;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vs[i], got, lat, to, pa, ra);
            checks++;
            if (to) begin errors++; $display("FAIL directed_%0d timeout waiting for out_valid", i); end
            checks++;
            if (got !== ve[i]) begin errors++; $display("FAIL directed_%0d result/cout/neg/err got %h exp %h", i, got, ve[i]); end
            checks++;
            if (lat != vl[i]) begin errors++; $display("FAIL directed_%0d latency got %0d exp %0d", i, lat, vl[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [18:0] got, pa;
        logic        ra;
        int          lat;
        bit          to;
        bus.out_ready = 1'b1;
        run_op(16'h0999, 16'h0001, 1'b0, got, lat, to, pa, ra);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_after_handshake got %b exp 1", bus.in_ready); end
        run_op(16'h0010, 16'h0020, 1'b1, got, lat, to, pa, ra);
        checks++;
        if (pa !== 19'd0) begin errors++; $display("FAIL b2b_cleared_on_accept got %h exp 0", pa); end
        checks++;
        if (ra !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_busy got %b exp 0", ra); end
        checks++;
        if (to || got !== {16'h0010, 3'b010} || lat != 8)
            begin errors++; $display("FAIL b2b_second_op got %h lat %0d exp %h lat 8", got, lat, {16'h0010, 3'b010}); end
    endtask

    task automatic test_random;
        logic [15:0] a, b, er;
        logic        s, ec, en, ee;
        logic [18:0] got, pa;
        logic        ra;
        int          lat, el;
        bit          to;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < D; i++) begin
                a[i*4 +: 4] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                b[i*4 +: 4] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            s = 1'($urandom_range(0, 1));
            model(a, b, s, er, ec, en, ee, el);
            run_op(a, b, s, got, lat, to, pa, ra);
            checks++;
            if (to || got !== {er, ec, en, ee} || lat != el)
                begin errors++; $display("FAIL random_%0d a=%h b=%h sub=%b got %h lat %0d exp %h lat %0d",
                                         n, a, b, s, got, lat, {er, ec, en, ee}, el); end
        end
    endtask

    task automatic test_backpressure;
        logic [18:0] snap;
        int          lat;
        bus.out_ready = 1'b0;
        bus.a = 16'h0456; bus.b = 16'h0789; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        // Offer a competing op while busy; it must be ignored.
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!bus.out_valid) begin errors++; $display("FAIL bp_timeout out_valid got 0 exp 1"); end
        snap = {bus.result, bus.cout, bus.neg, bus.err};
        checks++;
        if (snap !== {16'h1245, 3'b000}) begin errors++; $display("FAIL bp_result got %h exp %h", snap, {16'h1245, 3'b000}); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.neg, bus.err} !== {2'b10, snap})
                begin errors++; $display("FAIL bp_hold_%0d got %h exp %h", i,
                      {bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.neg, bus.err}, {2'b10, snap}); end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_release_same_cycle in_ready got %b exp 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            begin errors++; $display("FAIL bp_release_next_cycle in_ready/out_valid got %b exp 10", {bus.in_ready, bus.out_valid}); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] ra_op [2] = '{16'h1234, 16'h0100};
        logic [15:0] rb_op [2] = '{16'h4321, 16'h0250};
        logic        rs_op [2] = '{1'b0, 1'b1};
        int          wait_e [2] = '{2, 6};
        logic [18:0] got, pa;
        logic        rdy;
        int          lat;
        bit          to;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.a = ra_op[k]; bus.b = rb_op[k]; bus.sub = rs_op[k]; bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (wait_e[k]) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.result} !== {2'b10, 16'h0000})
                begin errors++; $display("FAIL rst_mid_%0d in_ready/out_valid/result got %h exp %h", k,
                      {bus.in_ready, bus.out_valid, bus.result}, {2'b10, 16'h0000}); end
            repeat (10) begin
                @(posedge clk); #1;
            end
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_%0d_no_result out_valid got %b exp 0", k, bus.out_valid); end
            run_op(16'h0250, 16'h0100, 1'b1, got, lat, to, pa, rdy);
            checks++;
            if (to || got !== {16'h0150, 3'b000} || lat != 4)
                begin errors++; $display("FAIL rst_mid_%0d_recover got %h lat %0d exp %h lat 4", k, got, lat, {16'h0150, 3'b000}); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        test_reset;
        test_directed;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
- Digit-serial, parametrised N-digit packed-BCD adder/subtractor with valid/ready handshakes on input and output.
- Processes one BCD digit per clock, least-significant digit (LSD) first, reusing a single 1-digit BCD adder and a registered carry.
- Subtraction returns sign plus magnitude: a negative ten's-complement intermediate is converted back in a second serial pass.
- Sits between the operand registers and the display/output stage of the BCD calculator datapath.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept operands.
- a  in  4*DIGITS  operand A, packed BCD; digit 0 = bits [3:0].
- b  in  4*DIGITS  operand B, packed BCD.
- sub  in  1  0: a+b, 1: a−b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  4*DIGITS  packed BCD sum, or magnitude of the difference.
- cout  out  1  add only: decimal carry out of the MSD, i.e. sum ≥ 10^DIGITS.
- neg  out  1  sub only: 1 when a < b.
- err  out  1  some digit of a or b is greater than 9.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, neg=0, err=0; FSM=IDLE; digit counter=0; carry register=0.
- Reset asserted in any state aborts the operation. No result is emitted, and the block is back in IDLE the cycle after reset deasserts.
- FSM states: IDLE, ADD, FIX, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, capture a, b and sub, and go to ADD.
  - Carry register initialises to sub (the +1 of ten's complement). Counter=0.
  - Later input changes are ignored.
- Operand validity: err is computed from the captured operands at acceptance.
  - If err=1, skip ADD/FIX and go to DONE after exactly DIGITS cycles (counter still runs).
  - Error result: result=0, cout=0, neg=0.
- ADD: one edge per digit i = 0..DIGITS−1.
  - Operand digit bi' = b[i] when sub=0, or 9−b[i] when sub=1.
  - Raw sum t = a[i] + bi' + carry, 5 bits.
  - If t > 9: digit = t+6 (low 4 bits), carry=1. Otherwise digit = t, carry=0.
  - Digit is written to the result register at position i.
  - After digit DIGITS−1, the final carry register value is the end carry:
    - sub=0: cout = end carry; go to DONE.
    - sub=1, end carry=1: neg=0; go to DONE.
    - sub=1, end carry=0: neg=1; reset counter; carry=1; go to FIX.
- FIX: one edge per digit. Each result digit r[i] is replaced by (9−r[i]) + carry, using the same BCD correction. This computes 10^DIGITS − r.
  - After digit DIGITS−1, go to DONE.
  - The end carry of FIX is discarded.
- DONE: out_valid=1.
  - result, cout, neg and err stay stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle turnaround.
- Latency, counted from the acceptance edge to the first cycle with out_valid=1:
  - DIGITS cycles for add, non-negative sub, or err.
  - 2*DIGITS cycles for negative sub.
- Throughput: one operation in flight. in_ready=0 in ADD, FIX and DONE.
- Output values outside DONE:
  - result and flags show their last DONE values.
  - They are cleared to 0 on acceptance of a new operation.
- Wrap-around: the add result is modulo 10^DIGITS, with overflow reported only via cout.
- sub with a==b: result=0, neg=0 (end carry=1), latency DIGITS.
- cout is always 0 for sub; neg is always 0 for add.

Test Plan:
- DIGITS=4, a=0x0456, b=0x0789, sub=0, out_ready=1 → result=0x1245, cout=0, neg=0, err=0; out_valid 4 cycles after accept.
- a=0x9999, b=0x0001, sub=0 → result=0x0000, cout=1; also 0x5000+0x5000 → 0x0000, cout=1.
- Subtraction:
  - a=0x0100, b=0x0250, sub=1 → result=0x0150, neg=1, latency 8.
  - a=0x0250, b=0x0100 → result=0x0150, neg=0, latency 4.
  - a=b=0x0042 → result=0x0000, neg=0.
- a=0x00A1, b=0x0001 → err=1, result=0, latency 4.
  - Follow with 0x0001+0x0001 → 0x0002, err=0, proving state is cleared.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and flags constant, in_ready=0; on release, in_ready rises 1 cycle later. Pulse in_valid during ADD → ignored.
- Reset: assert rst for 1 cycle mid-ADD (after 2 digits) and mid-FIX → next cycle in_ready=1, out_valid=0, result=0; a new operation then completes correctly.
